// File: rtl/mac_accumulate_stage_pkg.sv
// Shared definitions for the MAC accumulate path: state encodings, default widths
// and the signed-add overflow rule used by the saturating adder.
package mac_accumulate_stage_pkg;

   localparam int DEF_ACC_W = 72;
   localparam int DEF_CNT_W = 16;
   localparam int PROD_W    = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   // Two's-complement add overflows when both operands agree in sign and the result does not.
   function automatic logic signed_add_ovf(input logic a_s, input logic b_s, input logic s_s);
      return (a_s == b_s) && (s_s != a_s);
   endfunction

endpackage

// File: rtl/mac_accumulate_stage_if.sv
// Product-in / result-out handshake bundle between the multiplier, the accumulate stage and its consumer.
interface mac_accumulate_stage_if
   import mac_accumulate_stage_pkg::*;
#(
   parameter int ACC_W = DEF_ACC_W,
   parameter int CNT_W = DEF_CNT_W
);
   logic              in_valid;
   logic              in_ready;
   logic [PROD_W-1:0] in_prod;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_acc;
   logic [CNT_W-1:0]  out_count;
   logic              out_ovf;

   modport master (
      output in_valid, in_prod, in_last, out_ready,
      input  in_ready, out_valid, out_acc, out_count, out_ovf
   );

   modport slave (
      input  in_valid, in_prod, in_last, out_ready,
      output in_ready, out_valid, out_acc, out_count, out_ovf
   );
endinterface

// File: rtl/mac_accumulate_stage_sat_add.sv
// Combinational signed adder that either clamps to the W-bit signed range or wraps on overflow.
module sat_add
   import mac_accumulate_stage_pkg::*;
#(
   parameter int W   = DEF_ACC_W,
   parameter int SAT = 1
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         ovf
);
   logic [W-1:0] raw;

   assign raw = a + b;
   assign ovf = signed_add_ovf(a[W-1], b[W-1], raw[W-1]);

   // On overflow both operands share a sign, so that sign picks the rail.
   always_comb begin
      sum = raw;
      if (ovf && (SAT != 0))
         sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
   end
endmodule

// File: rtl/mac_accumulate_stage.sv
// Burst accumulator behind the 32x32 multiplier: sums sign-extended products, closes on
// in_last or MAX_TERMS, then holds the registered result until the consumer takes it.
module mac_accumulate_stage
   import mac_accumulate_stage_pkg::*;
#(
   parameter int ACC_W     = DEF_ACC_W,
   parameter int CNT_W     = DEF_CNT_W,
   parameter int MAX_TERMS = 256,
   parameter int SAT       = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   mac_accumulate_stage_if.slave  bus
);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

   state_t           state, state_nxt;
   logic [ACC_W-1:0] acc, prod_ext, add_sum;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             ovf, add_ovf;
   logic             in_ready, out_valid;
   logic             beat, out_xfer, closing;

   assign prod_ext = ACC_W'($signed(bus.in_prod));
   assign beat     = bus.in_valid & in_ready;
   assign out_xfer = out_valid & bus.out_ready;

   // The first beat of a burst counts as term 1, so one compare covers MAX_TERMS==1 too.
   assign cnt_nxt  = (state == ST_IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
   assign closing  = bus.in_last | (cnt_nxt == MAX_CNT);

   sat_add #(.W(ACC_W), .SAT(SAT)) u_add (
      .a   (acc),
      .b   (prod_ext),
      .sum (add_sum),
      .ovf (add_ovf)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_ACCUM: if (beat) state_nxt = closing ? ST_HOLD : ST_ACCUM;
         ST_HOLD:           if (out_xfer) state_nxt = ST_IDLE;
         default:           state_nxt = ST_IDLE;
      endcase
   end

   // in_ready is masked by rst so nothing looks acceptable while reset is held.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ST_IDLE, ST_ACCUM: in_ready  = ~rst;
         ST_HOLD:           out_valid = 1'b1;
         default:           ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (beat) begin
         cnt <= cnt_nxt;
         if (state == ST_IDLE) begin
            acc <= prod_ext;
            ovf <= 1'b0;
         end else begin
            acc <= add_sum;
            ovf <= ovf | add_ovf;
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_acc   = acc;
   assign bus.out_count = cnt;
   assign bus.out_ovf   = ovf;
endmodule

// File: tb/tb_mac_accumulate_stage.sv
// Directed and randomized checks of the accumulate stage across four parameterizations fed from shared stimulus.
module tb_mac_accumulate_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [63:0] in_prod = '0;
   logic        in_last = 1'b0;
   logic        out_ready = 1'b0;
   int          ntests = 0;
   int          nfail  = 0;

   always #5 clk = ~clk;

   mac_accumulate_stage_if #(.ACC_W(72), .CNT_W(16)) if_main ();
   mac_accumulate_stage_if #(.ACC_W(72), .CNT_W(16)) if_m4 ();
   mac_accumulate_stage_if #(.ACC_W(64), .CNT_W(16)) if_sat ();
   mac_accumulate_stage_if #(.ACC_W(64), .CNT_W(16)) if_wrap ();

   assign if_main.in_valid = in_valid;  assign if_main.in_prod = in_prod;
   assign if_main.in_last  = in_last;   assign if_main.out_ready = out_ready;
   assign if_m4.in_valid   = in_valid;  assign if_m4.in_prod   = in_prod;
   assign if_m4.in_last    = in_last;   assign if_m4.out_ready   = out_ready;
   assign if_sat.in_valid  = in_valid;  assign if_sat.in_prod  = in_prod;
   assign if_sat.in_last   = in_last;   assign if_sat.out_ready  = out_ready;
   assign if_wrap.in_valid = in_valid;  assign if_wrap.in_prod = in_prod;
   assign if_wrap.in_last  = in_last;   assign if_wrap.out_ready = out_ready;

   mac_accumulate_stage #(.ACC_W(72), .CNT_W(16), .MAX_TERMS(256), .SAT(1))
      u_main (.clk(clk), .rst(rst), .bus(if_main));
   mac_accumulate_stage #(.ACC_W(72), .CNT_W(16), .MAX_TERMS(4), .SAT(1))
      u_m4 (.clk(clk), .rst(rst), .bus(if_m4));
   mac_accumulate_stage #(.ACC_W(64), .CNT_W(16), .MAX_TERMS(256), .SAT(1))
      u_sat (.clk(clk), .rst(rst), .bus(if_sat));
   mac_accumulate_stage #(.ACC_W(64), .CNT_W(16), .MAX_TERMS(256), .SAT(0))
      u_wrap (.clk(clk), .rst(rst), .bus(if_wrap));

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic rdy(input int id);
      case (id)
         0:       return if_main.in_ready;
         1:       return if_m4.in_ready;
         2:       return if_sat.in_ready;
         default: return if_wrap.in_ready;
      endcase
   endfunction

   // Holds a beat until the chosen instance takes it; returns 1 ns after the accepting edge.
   task automatic push(input int id, input logic [63:0] p, input logic last);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_prod  = p;
      in_last  = last;
      @(negedge clk);
      while (!rdy(id) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         ntests++;
         nfail++;
         $error("FAIL push_timeout: observed no in_ready within %0d cycles, expected acceptance", n);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      in_last  = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      logic signed [127:0] ref_s, lim_hi, lim_lo;
      logic                ref_ovf;
      logic [31:0]         ma, mb;
      longint              pa, pb, pp;
      int                  len;

      // reset state
      #12;
      chk("rst_in_ready",  if_main.in_ready,  1'b0);
      chk("rst_out_valid", if_main.out_valid, 1'b0);
      chk("rst_acc",       if_main.out_acc,   72'd0);
      chk("rst_count",     if_main.out_count, 16'd0);
      chk("rst_ovf",       if_main.out_ovf,   1'b0);
      @(posedge clk); #1 rst = 1'b0;

      // basic burst {3,-5,7}
      out_ready = 1'b1;
      push(0, 64'd3, 1'b0);
      push(0, -64'sd5, 1'b0);
      push(0, 64'd7, 1'b1);
      chk("b1_valid", if_main.out_valid, 1'b1);
      chk("b1_acc",   if_main.out_acc,   72'd5);
      chk("b1_count", if_main.out_count, 16'd3);
      chk("b1_ovf",   if_main.out_ovf,   1'b0);
      chk("b1_ready", if_main.in_ready,  1'b0);
      @(posedge clk); #1;
      chk("b1_drop",  if_main.out_valid, 1'b0);

      // MAX_TERMS=4 auto-close, then the remaining beats start a new burst
      do_reset();
      out_ready = 1'b0;
      repeat (4) push(1, 64'd2, 1'b0);
      chk("m4_valid", if_m4.out_valid, 1'b1);
      chk("m4_acc",   if_m4.out_acc,   72'd8);
      chk("m4_count", if_m4.out_count, 16'd4);
      chk("m4_ready", if_m4.in_ready,  1'b0);
      out_ready = 1'b1;
      push(1, 64'd2, 1'b0);
      chk("m4_b5_valid", if_m4.out_valid, 1'b0);
      chk("m4_b5_count", if_m4.out_count, 16'd1);
      push(1, 64'd2, 1'b0);
      chk("m4_b6_acc",   if_m4.out_acc,   72'd4);
      chk("m4_b6_count", if_m4.out_count, 16'd2);

      // positive overflow: clamp vs wrap at 64 bits, no overflow at 72 bits
      do_reset();
      out_ready = 1'b1;
      push(2, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
      push(2, 64'd1, 1'b1);
      chk("sat_acc",   if_sat.out_acc,   72'h7FFF_FFFF_FFFF_FFFF);
      chk("sat_ovf",   if_sat.out_ovf,   1'b1);
      chk("wrap_acc",  if_wrap.out_acc,  72'h8000_0000_0000_0000);
      chk("wrap_ovf",  if_wrap.out_ovf,  1'b1);
      chk("wide_acc",  if_main.out_acc,  72'h00_8000_0000_0000_0000);
      chk("wide_ovf",  if_main.out_ovf,  1'b0);
      // negative overflow
      push(2, 64'h8000_0000_0000_0000, 1'b0);
      push(2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      chk("nsat_acc",  if_sat.out_acc,   72'h8000_0000_0000_0000);
      chk("nsat_ovf",  if_sat.out_ovf,   1'b1);
      chk("nwrap_acc", if_wrap.out_acc,  72'h7FFF_FFFF_FFFF_FFFF);
      chk("nwrap_ovf", if_wrap.out_ovf,  1'b1);

      // consumer backpressure in HOLD while the producer keeps offering a beat
      do_reset();
      out_ready = 1'b0;
      push(0, 64'd10, 1'b0);
      push(0, 64'd20, 1'b1);
      in_valid = 1'b1; in_prod = 64'd99; in_last = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         chk("hold_valid", if_main.out_valid, 1'b1);
         chk("hold_acc",   if_main.out_acc,   72'd30);
         chk("hold_ready", if_main.in_ready,  1'b0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("rel_valid", if_main.out_valid, 1'b0);
      chk("rel_ready", if_main.in_ready,  1'b1);
      chk("rel_acc",   if_main.out_acc,   72'd30);
      chk("rel_count", if_main.out_count, 16'd2);
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      chk("next_valid", if_main.out_valid, 1'b1);
      chk("next_acc",   if_main.out_acc,   72'd99);
      chk("next_count", if_main.out_count, 16'd1);
      @(posedge clk); #1;

      // asynchronous reset mid-burst
      push(0, 64'd5, 1'b0);
      push(0, 64'd6, 1'b0);
      chk("mid_acc", if_main.out_acc, 72'd11);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", if_main.out_valid, 1'b0);
      chk("arst_acc",   if_main.out_acc,   72'd0);
      chk("arst_count", if_main.out_count, 16'd0);
      chk("arst_ready", if_main.in_ready,  1'b0);
      @(posedge clk); #1 rst = 1'b0;
      push(0, -64'sd4, 1'b1);
      chk("post_acc",   if_main.out_acc,   72'hFF_FFFF_FFFF_FFFF_FFFC);
      chk("post_count", if_main.out_count, 16'd1);
      chk("post_valid", if_main.out_valid, 1'b1);
      @(posedge clk); #1;

      // randomized bursts of multiplier products with stalls on both sides
      lim_hi = (128'sd1 <<< 71) - 128'sd1;
      lim_lo = -(128'sd1 <<< 71);
      for (int b = 0; b < 1000; b++) begin
         len = $urandom_range(1, 8);
         ref_s = '0;
         ref_ovf = 1'b0;
         out_ready = 1'($urandom_range(0, 1));
         for (int k = 0; k < len; k++) begin
            repeat ($urandom_range(0, 2)) begin
               in_valid = 1'b0;
               in_prod  = {$urandom, $urandom};
               in_last  = 1'($urandom_range(0, 1));
               @(posedge clk); #1;
            end
            ma = $urandom;
            mb = $urandom;
            if ($urandom_range(0, 7) == 0) ma = 32'h8000_0000;
            if ($urandom_range(0, 7) == 0) mb = 32'h8000_0000;
            pa = longint'($signed(ma));
            pb = longint'($signed(mb));
            pp = pa * pb;
            ref_s = ref_s + 128'(pp);
            if (ref_s > lim_hi) begin ref_s = lim_hi; ref_ovf = 1'b1; end
            if (ref_s < lim_lo) begin ref_s = lim_lo; ref_ovf = 1'b1; end
            push(0, 64'(pp), k == len - 1);
         end
         chk("rand_valid", if_main.out_valid, 1'b1);
         chk("rand_acc",   if_main.out_acc,   ref_s[71:0]);
         chk("rand_count", if_main.out_count, 16'(len));
         chk("rand_ovf",   if_main.out_ovf,   ref_ovf);
         if (!out_ready) begin
            repeat ($urandom_range(0, 3)) begin
               @(posedge clk); #1;
               chk("rand_hold", if_main.out_valid, 1'b1);
            end
            out_ready = 1'b1;
         end
         @(posedge clk); #1;
         chk("rand_drop", if_main.out_valid, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
